// File: rtl/lanectrl_pause_sync_multi.sv
// -----------------------------------------------------------------------------
// lanectrl_pause_sync_multi
//
// Multi-lane pause synchroniser between the DDR training/control logic and the
// per-lane LANECTRL blocks. Each lane's asynchronous HS_IO_CLK_PAUSE request is
// brought into the CLK domain through a SYNC_STAGES-deep flop chain. A per-lane
// FSM then stretches every pause to at least MIN_PAUSE_CYCLES cycles. With
// GROUP_MODE set, all enabled lanes follow the OR of the enabled lanes' requests.
// With FALL_EDGE_OUT set, the lane outputs are retimed by one falling-edge flop.
//
// Ports:
//   CLK                   lane control clock
//   RESET                 asynchronous, active-high reset
//   LANE_EN[N-1:0]        per-lane enable (CLK-synchronous)
//   HS_IO_CLK_PAUSE[N-1:0]      asynchronous pause requests
//   HS_IO_CLK_PAUSE_SYNC[N-1:0] synchronised, stretched pause to LANECTRL
//   PAUSE_DONE[N-1:0]     1-cycle pulse when a pause window ends naturally
//   ANY_PAUSE             OR of all lane pauses, taken before the fall retime
// -----------------------------------------------------------------------------
module lanectrl_pause_sync_multi #(
  parameter int NUM_LANES        = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 2,
  parameter int GROUP_MODE       = 0,
  parameter int FALL_EDGE_OUT    = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] LANE_EN,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic [NUM_LANES-1:0] PAUSE_DONE,
  output logic                 ANY_PAUSE
);

  localparam int CNT_W = $clog2(MIN_PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_PAUSE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  // --- Stage: synchroniser chain (sync_q[0] is the capture flop) ---
  (* syn_keep = 1, HS_IO_CLK_PAUSE_SYNC = 1 *)
  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], HS_IO_CLK_PAUSE};
    end
  end

  logic [NUM_LANES-1:0] s_raw;
  logic                 s_grp;
  logic [NUM_LANES-1:0] s_eff;

  assign s_raw = sync_q[SYNC_STAGES-1];
  // Only enabled lanes contribute to the ganged request, so a disabled lane
  // with a stuck input cannot pause the group.
  assign s_grp = |(s_raw & LANE_EN);
  assign s_eff = (GROUP_MODE != 0) ? {NUM_LANES{s_grp}} : s_raw;

  // --- Stage: per-lane stretch FSM ---
  logic [NUM_LANES-1:0][1:0]       state_q, state_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0]            out_d, done_d;
  (* syn_keep = 1, HS_IO_CLK_PAUSE_SYNC = 1 *)
  logic [NUM_LANES-1:0]            out_q;
  logic [NUM_LANES-1:0]            done_q;
  logic                            any_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    out_d   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!LANE_EN[i]) begin
        // Disabling a lane aborts its pause silently.
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (s_eff[i]) begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = CNT_LOAD;
            end
          end
          ST_HOLD: begin
            // Input drops are ignored until the minimum window has elapsed.
            if (cnt_q[i] == '0) begin
              if (s_eff[i]) begin
                state_d[i] = ST_TRACK;
              end else begin
                state_d[i] = ST_IDLE;
                done_d[i]  = 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          ST_TRACK: begin
            if (!s_eff[i]) begin
              state_d[i] = ST_IDLE;
              done_d[i]  = 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      out_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      any_q   <= |out_d;
    end
  end

  assign PAUSE_DONE = done_q;
  assign ANY_PAUSE  = any_q;

  // --- Stage: optional falling-edge retime of the lane outputs ---
  if (FALL_EDGE_OUT != 0) begin : g_fall
    (* syn_keep = 1, HS_IO_CLK_PAUSE_SYNC = 1 *)
    logic [NUM_LANES-1:0] fall_q;

    always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
        fall_q <= '0;
      end else begin
        fall_q <= out_q;
      end
    end

    assign HS_IO_CLK_PAUSE_SYNC = fall_q;
  end else begin : g_rise
    assign HS_IO_CLK_PAUSE_SYNC = out_q;
  end

endmodule

// File: tb/tb_lanectrl_pause_sync_multi.sv
// -----------------------------------------------------------------------------
// tb_lanectrl_pause_sync_multi
//
// Four configurations of lanectrl_pause_sync_multi share one set of inputs:
//   inst0: defaults              inst1: MIN_PAUSE_CYCLES=4
//   inst2: GROUP_MODE=1          inst3: SYNC_STAGES=3, FALL_EDGE_OUT=1
// A behavioural model (delay line of input samples plus an "age since pause
// start" per lane) predicts every output each cycle; a vector table and
// directed sequences add hand-derived expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_lanectrl_pause_sync_multi;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] LANE_EN = 4'h0;
  logic [3:0] PAUSE = 4'h0;

  logic [3:0] sync_a, sync_b, sync_c, sync_d;
  logic [3:0] done_a, done_b, done_c, done_d;
  logic       any_a, any_b, any_c, any_d;

  logic [3:0] sync_w [4];
  logic [3:0] done_w [4];
  logic [3:0] any_w;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  lanectrl_pause_sync_multi #(.NUM_LANES(4), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(2),
    .GROUP_MODE(0), .FALL_EDGE_OUT(0)) u_a (
    .CLK(CLK), .RESET(RESET), .LANE_EN(LANE_EN), .HS_IO_CLK_PAUSE(PAUSE),
    .HS_IO_CLK_PAUSE_SYNC(sync_a), .PAUSE_DONE(done_a), .ANY_PAUSE(any_a));

  lanectrl_pause_sync_multi #(.NUM_LANES(4), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(4),
    .GROUP_MODE(0), .FALL_EDGE_OUT(0)) u_b (
    .CLK(CLK), .RESET(RESET), .LANE_EN(LANE_EN), .HS_IO_CLK_PAUSE(PAUSE),
    .HS_IO_CLK_PAUSE_SYNC(sync_b), .PAUSE_DONE(done_b), .ANY_PAUSE(any_b));

  lanectrl_pause_sync_multi #(.NUM_LANES(4), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(2),
    .GROUP_MODE(1), .FALL_EDGE_OUT(0)) u_c (
    .CLK(CLK), .RESET(RESET), .LANE_EN(LANE_EN), .HS_IO_CLK_PAUSE(PAUSE),
    .HS_IO_CLK_PAUSE_SYNC(sync_c), .PAUSE_DONE(done_c), .ANY_PAUSE(any_c));

  lanectrl_pause_sync_multi #(.NUM_LANES(4), .SYNC_STAGES(3), .MIN_PAUSE_CYCLES(2),
    .GROUP_MODE(0), .FALL_EDGE_OUT(1)) u_d (
    .CLK(CLK), .RESET(RESET), .LANE_EN(LANE_EN), .HS_IO_CLK_PAUSE(PAUSE),
    .HS_IO_CLK_PAUSE_SYNC(sync_d), .PAUSE_DONE(done_d), .ANY_PAUSE(any_d));

  always_comb begin
    sync_w[0] = sync_a; sync_w[1] = sync_b; sync_w[2] = sync_c; sync_w[3] = sync_d;
    done_w[0] = done_a; done_w[1] = done_b; done_w[2] = done_c; done_w[3] = done_d;
    any_w     = {any_d, any_c, any_b, any_a};
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         p_ss   [4] = '{2, 2, 2, 3};
  int         p_min  [4] = '{2, 4, 2, 2};
  bit         p_grp  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit         p_fall [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [3:0] hist   [4];   // hist[k] = input sample taken k+1 edges ago
  logic [3:0] m_act  [4];   // lane currently paused
  int         m_age  [4][4];
  logic [3:0] m_done [4];
  logic [3:0] m_sync [4];
  logic [3:0] ms, mold;
  logic       mg, mse;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < 4; n++) begin
        hist[n]   = '0;
        m_act[n]  = '0;
        m_done[n] = '0;
        m_sync[n] = '0;
        for (int l = 0; l < 4; l++) m_age[n][l] = 0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        ms   = hist[p_ss[n]-1];
        mg   = |(ms & LANE_EN);
        mold = m_act[n];
        m_done[n] = '0;
        for (int l = 0; l < 4; l++) begin
          mse = p_grp[n] ? mg : ms[l];
          if (!LANE_EN[l]) begin
            m_act[n][l] = 1'b0;
          end else if (!m_act[n][l]) begin
            if (mse) begin
              m_act[n][l] = 1'b1;
              m_age[n][l] = 1;
            end
          end else if (m_age[n][l] < p_min[n]) begin
            m_age[n][l] = m_age[n][l] + 1;
          end else if (!mse) begin
            m_act[n][l]  = 1'b0;
            m_done[n][l] = 1'b1;
          end
        end
        m_sync[n] = p_fall[n] ? mold : m_act[n];
      end
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = PAUSE;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic cmp(input string nm, input int n, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s inst%0d: got %b, expected %b at t=%0t", nm, n, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < 4; n++) begin
      cmp({tag, "/sync"}, n, sync_w[n], m_sync[n]);
      cmp({tag, "/done"}, n, done_w[n], m_done[n]);
      cmp({tag, "/any"},  n, {3'b000, any_w[n]}, {3'b000, |m_act[n]});
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] pause;
    logic [3:0] a_sync;
    logic [3:0] a_done;
    logic [3:0] c_sync;
    logic       d_any;
    logic [3:0] d_sync;
  } vec_t;

  vec_t vt [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_a, cnt_b, dc_b, miss, gc, g2, first_a, first_d;

    // Vector table: lane0 held high for edges 0..9 with all lanes enabled.
    for (int k = 0; k < 16; k++) begin
      vt[k].en     = 4'hF;
      vt[k].pause  = (k < 10) ? 4'b0001 : 4'b0000;
      vt[k].a_sync = (k >= 2 && k <= 11) ? 4'b0001 : 4'b0000;
      vt[k].a_done = (k == 12) ? 4'b0001 : 4'b0000;
      vt[k].c_sync = (k >= 2 && k <= 11) ? 4'b1111 : 4'b0000;
      vt[k].d_any  = (k >= 3 && k <= 12);
      vt[k].d_sync = (k >= 4 && k <= 13) ? 4'b0001 : 4'b0000;
    end

    // Reset state
    #1 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    for (int n = 0; n < 4; n++) begin
      cmp("reset_sync", n, sync_w[n], 4'b0000);
      cmp("reset_done", n, done_w[n], 4'b0000);
      cmp("reset_any",  n, {3'b000, any_w[n]}, 4'b0000);
    end
    RESET   = 1'b0;
    LANE_EN = 4'hF;
    repeat (4) cyc("idle");

    // Table-driven basic pause
    for (int k = 0; k < 16; k++) begin
      LANE_EN = vt[k].en;
      PAUSE   = vt[k].pause;
      cyc("table");
      cmp("tbl_a_sync", 0, sync_w[0], vt[k].a_sync);
      cmp("tbl_a_done", 0, done_w[0], vt[k].a_done);
      cmp("tbl_b_sync", 1, sync_w[1], vt[k].a_sync);
      cmp("tbl_c_sync", 2, sync_w[2], vt[k].c_sync);
      cmp("tbl_d_any",  3, {3'b000, any_w[3]}, {3'b000, vt[k].d_any});
      cmp("tbl_d_sync", 3, sync_w[3], vt[k].d_sync);
      if (k == 3) begin
        @(negedge CLK);
        #1;
        cmp("fall_half_cycle", 3, sync_w[3], 4'b0001);
      end
    end

    // Sub-cycle glitch on lane1 straddling an edge: exactly MIN cycles
    PAUSE = 4'h0;
    repeat (2) cyc("pre_glitch");
    #7 PAUSE = 4'b0010;
    @(posedge CLK);
    #1;
    check_all("glitch");
    PAUSE = 4'h0;
    cnt_a = 0; cnt_b = 0; dc_b = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("glitch");
      if (sync_w[0][1]) cnt_a++;
      if (sync_w[1][1]) cnt_b++;
      if (done_w[1][1]) dc_b++;
    end
    cmp("glitch_width_min2", 0, 4'(cnt_a), 4'd2);
    cmp("glitch_width_min4", 1, 4'(cnt_b), 4'd4);
    cmp("glitch_done_count", 1, 4'(dc_b), 4'd1);

    // Glitch between edges is never captured
    #2 PAUSE = 4'b0100;
    #3 PAUSE = 4'h0;
    miss = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("missed_glitch");
      if (sync_w[0] != 0 || sync_w[1] != 0 || sync_w[2] != 0 || any_w != 0) miss++;
    end
    cmp("missed_glitch", 0, 4'(miss), 4'd0);

    // Group mode: lane3 pulses 5 cycles with LANE_EN=1011
    LANE_EN = 4'b1011;
    gc = 0; g2 = 0;
    for (int i = 0; i < 14; i++) begin
      PAUSE = (i < 5) ? 4'b1000 : 4'b0000;
      cyc("group");
      if (sync_w[2] == 4'b1011) gc++;
      if (sync_w[2][2]) g2++;
    end
    cmp("group_width", 2, 4'(gc), 4'd5);
    cmp("group_lane2_off", 2, 4'(g2), 4'd0);

    // LANE_EN[0] cleared during TRACK, then re-enabled with input still high
    LANE_EN = 4'hF;
    PAUSE   = 4'b0001;
    repeat (6) cyc("en_drop");
    LANE_EN = 4'b1110;
    cyc("en_drop");
    cmp("en_drop_sync", 0, {3'b000, sync_w[0][0]}, 4'd0);
    cmp("en_drop_done", 0, {3'b000, done_w[0][0]}, 4'd0);
    LANE_EN = 4'hF;
    cyc("reenable");
    cmp("reenable_sync", 0, {3'b000, sync_w[0][0]}, 4'd1);
    PAUSE = 4'h0;
    repeat (8) cyc("en_drop_tail");

    // Reset asserted mid-HOLD
    PAUSE = 4'b0001;
    repeat (3) cyc("rst_hold");
    cmp("rst_pre_hold", 0, {3'b000, sync_w[0][0]}, 4'd1);
    #2 RESET = 1'b1;
    #1;
    check_all("rst_async");
    cmp("rst_async_sync", 0, sync_w[0], 4'b0000);
    cmp("rst_async_any", 0, any_w, 4'b0000);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    first_a = 0; first_d = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc("rst_release");
      if (first_a == 0 && sync_w[0][0]) first_a = i;
      if (first_d == 0 && any_w[3]) first_d = i;
    end
    cmp("rst_relatch_a", 0, 4'(first_a), 4'd3);
    cmp("rst_relatch_d", 3, 4'(first_d), 4'd4);
    PAUSE = 4'h0;
    repeat (8) cyc("rst_tail");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 3) == 0) PAUSE[l] = ~PAUSE[l];
      end
      if ($urandom_range(0, 15) == 0) LANE_EN = 4'($urandom);
      else if ($urandom_range(0, 3) == 0) LANE_EN = 4'hF;
      if ($urandom_range(0, 149) == 0) begin
        #1 RESET = 1'b1;
        #1 check_all("rand_rst");
        #1 RESET = 1'b0;
      end
      cyc("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lanectrl_pause_sync_multi.md
Name: lanectrl_pause_sync_multi

Overview:
Multi-lane successor to the single-lane DDR PHY lane-control pause synchroniser. It takes one asynchronous HS_IO_CLK_PAUSE request per lane and synchronises it into the CLK domain through a configurable-depth flop chain. It stretches each pause to a guaranteed minimum width and can gang all lanes so they pause together. It can also retime outputs to the falling edge. It sits between the DDR training/control logic and the per-lane LANECTRL blocks of the DDRPHY.

Parameters:
NUM_LANES, 4, number of independent pause channels (1..16)
SYNC_STAGES, 2, synchroniser depth in CLK flops (2..4)
MIN_PAUSE_CYCLES, 2, minimum asserted width of each output pause in CLK cycles (1..15; 1 = no stretching)
GROUP_MODE, 0, 1 = every enabled lane outputs the OR of all enabled lanes' pauses
FALL_EDGE_OUT, 0, 1 = add one falling-edge CLK retiming flop on HS_IO_CLK_PAUSE_SYNC

Ports:
CLK  input  1  lane control clock
RESET  input  1  asynchronous, active-high reset
LANE_EN  input  NUM_LANES  per-lane enable, CLK-synchronous
HS_IO_CLK_PAUSE  input  NUM_LANES  asynchronous pause requests
HS_IO_CLK_PAUSE_SYNC  output  NUM_LANES  synchronised, stretched pause to LANECTRL
PAUSE_DONE  output  NUM_LANES  1-cycle pulse when a lane's pause window ends naturally
ANY_PAUSE  output  1  OR of HS_IO_CLK_PAUSE_SYNC before the fall-edge retime

Behaviour:
- Reset:
  - RESET is asynchronous and active-high; clock is CLK.
  - All sync flops, FSMs, counters, HS_IO_CLK_PAUSE_SYNC, PAUSE_DONE and ANY_PAUSE go to 0.
  - Reset mid-pause drops outputs immediately; no PAUSE_DONE is generated.
- Synchroniser:
  - Per lane, sync[0..SYNC_STAGES-1] shift on every posedge CLK, independent of LANE_EN.
  - s_i = sync[SYNC_STAGES-1]. In GROUP_MODE, s_i = OR over enabled lanes of their s.
- Per-lane FSM (posedge CLK), with counter cnt of width clog2(MIN_PAUSE_CYCLES+1):
  - IDLE: out=0. If LANE_EN and s_i=1 -> HOLD, out=1, cnt=MIN_PAUSE_CYCLES-1.
  - HOLD: out=1, cnt decrements each cycle. When cnt=0: if s_i=1 -> TRACK; else -> IDLE with out=0 and PAUSE_DONE=1 for one cycle. Input dropping during HOLD is ignored.
  - TRACK: out=1 while s_i=1. When s_i=0 -> IDLE, out=0, PAUSE_DONE pulse.
  - Any state with LANE_EN=0: next state IDLE, out=0, no PAUSE_DONE.
  - Re-assertion in the same cycle the FSM returns to IDLE starts a new pause on the next edge, so there is at least one low cycle between pauses.
- Latency:
  - Input rises before edge 0; out=1 after edge SYNC_STAGES (3 edges for the default).
  - Deassert latency equals assert latency, unless stretching applies.
- Widths:
  - Every output pause is at least MIN_PAUSE_CYCLES cycles; a sub-cycle input glitch that is captured yields exactly MIN_PAUSE_CYCLES cycles.
  - A glitch missed by sync[0] yields no pause.
- ANY_PAUSE and PAUSE_DONE are registered with out.
- FALL_EDGE_OUT=1: HS_IO_CLK_PAUSE_SYNC = out sampled on negedge CLK, adding a half-cycle delay. ANY_PAUSE and PAUSE_DONE are not retimed.
- The sync flops and the output flop carry the syn_keep attribute and the HS_IO_CLK_PAUSE_SYNC attribute.

Test Plan:
- Defaults; lane0 held high 10 cycles from edge 0 -> SYNC[0]=1 after edge 2, stays through edge 11, falls after edge 12; PAUSE_DONE[0] pulses at edge 12.
- MIN_PAUSE_CYCLES=4; 0.3-cycle glitch on lane1 captured at edge 5 -> SYNC[1]=1 for exactly 4 cycles (edges 7..10); one PAUSE_DONE pulse.
- GROUP_MODE=1, LANE_EN=4'b1011; lane3 pulses 5 cycles -> SYNC=4'b1011 for 5 cycles with identical edges; lane2 stays 0.
- LANE_EN[0] cleared during TRACK -> SYNC[0]=0 on the next edge, no PAUSE_DONE; re-enable while the input is still high -> new pause after 1 cycle.
- RESET asserted mid-HOLD -> all outputs 0 asynchronously. After release with the input high -> pause re-asserts SYNC_STAGES edges later.
- FALL_EDGE_OUT=1, SYNC_STAGES=3 -> SYNC rises half a cycle after ANY_PAUSE (ANY_PAUSE at edge 3, SYNC at negedge following edge 3).
